// File: rtl/label_bbox_accumulator.sv
// Per-label bounding box and pixel-count accumulator over one frame of labelled pixels.
// On vsync the non-empty entries drain in index order over a valid/ready port, then the table is clear.
module label_bbox_accumulator #(
  parameter int WORD_SIZE   = 8,
  parameter int NUM_LABELS  = 32,
  parameter int COORD_WIDTH = 11,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [WORD_SIZE-1:0]   label,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_SIZE-1:0]   out_label,
  output logic [COORD_WIDTH-1:0] out_xmin,
  output logic [COORD_WIDTH-1:0] out_xmax,
  output logic [COORD_WIDTH-1:0] out_ymin,
  output logic [COORD_WIDTH-1:0] out_ymax,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   frame_done,
  output logic                   dropped
);

  localparam int IDX_W = $clog2(NUM_LABELS);
  localparam logic [IDX_W-1:0]     FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_LABELS - 1);
  localparam logic [WORD_SIZE-1:0] MAX_LABEL = WORD_SIZE'(NUM_LABELS - 1);

  typedef enum logic {ACCUM, DUMP} state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [COORD_WIDTH-1:0] x, y;

  logic [COUNT_WIDTH-1:0] count [NUM_LABELS];
  logic [COORD_WIDTH-1:0] xmin  [NUM_LABELS];
  logic [COORD_WIDTH-1:0] xmax  [NUM_LABELS];
  logic [COORD_WIDTH-1:0] ymin  [NUM_LABELS];
  logic [COORD_WIDTH-1:0] ymax  [NUM_LABELS];

  logic             pixel_ok;
  logic             first_hit;
  logic [IDX_W-1:0] pix_idx;
  logic             entry_done;
  logic             last_done;

  // Background (0), conflict (all ones) and labels beyond the table are not tracked.
  assign pix_idx   = label[IDX_W-1:0];
  assign pixel_ok  = (state == ACCUM) && en && (label != '0) && (label != '1)
                     && (label <= MAX_LABEL);
  assign first_hit = (count[pix_idx] == '0);

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    entry_done = 1'b0;
    last_done  = 1'b0;
    if (state == DUMP) begin
      out_valid  = (count[idx] != '0);
      entry_done = !out_valid || out_ready;
      last_done  = entry_done && (idx == LAST_IDX);
      if (last_done) state_next = ACCUM;
    end else if (vsync) begin
      state_next = DUMP;
    end
  end

  assign out_label = WORD_SIZE'(idx);
  assign out_xmin  = xmin[idx];
  assign out_xmax  = xmax[idx];
  assign out_ymin  = ymin[idx];
  assign out_ymax  = ymax[idx];
  assign out_count = count[idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ACCUM;
      idx        <= FIRST_IDX;
      frame_done <= 1'b0;
      dropped    <= 1'b0;
      x          <= '0;
      y          <= '0;
    end else begin
      state      <= state_next;
      frame_done <= last_done;
      if (state == ACCUM && vsync) idx <= FIRST_IDX;
      else if (entry_done)         idx <= idx + 1'b1;
      if (state == DUMP && (en || vsync)) dropped <= 1'b1;
      // The pixel on an en+sync cycle has already used the pre-update coordinates.
      if (vsync) begin
        x <= '0;
        y <= '0;
      end else if (hsync) begin
        x <= '0;
        y <= y + 1'b1;
      end else if (en) begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LABELS; i++) count[i] <= '0;
    end else if (pixel_ok) begin
      if (first_hit)                  count[pix_idx] <= COUNT_WIDTH'(1);
      else if (count[pix_idx] != '1)  count[pix_idx] <= count[pix_idx] + 1'b1;
    end else if (out_valid && out_ready) begin
      count[idx] <= '0;
    end
  end

  // NOTE: box fields are only meaningful while count is non-zero, so they need no reset.
  always_ff @(posedge clk) begin
    if (pixel_ok) begin
      if (first_hit || x < xmin[pix_idx]) xmin[pix_idx] <= x;
      if (first_hit || x > xmax[pix_idx]) xmax[pix_idx] <= x;
      if (first_hit || y < ymin[pix_idx]) ymin[pix_idx] <= y;
      if (first_hit || y > ymax[pix_idx]) ymax[pix_idx] <= y;
    end
  end

endmodule

// File: tb/tb_label_bbox_accumulator.sv
// Self-checking bench for label_bbox_accumulator: directed scenarios plus random frames,
// compared against a per-label table model built from plain arithmetic.
module tb_label_bbox_accumulator;

  localparam int NL = 32;

  logic        clk = 1'b0;
  logic        reset_n, en, hsync, vsync, out_ready;
  logic [7:0]  label;
  logic        out_valid, frame_done, dropped;
  logic [7:0]  out_label;
  logic [10:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  label_bbox_accumulator dut (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .label(label),
    .out_valid(out_valid), .out_ready(out_ready), .out_label(out_label),
    .out_xmin(out_xmin), .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .out_count(out_count), .frame_done(frame_done), .dropped(dropped)
  );

  typedef struct {
    int lbl;
    int xmin, xmax, ymin, ymax, cnt;
  } ent_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cnt [NL];
  int   m_xmin[NL], m_xmax[NL], m_ymin[NL], m_ymax[NL];
  int   mx, my;
  bit   exp_drop;
  int   last_stalls;
  ent_t exp_q[$];
  ent_t xfer_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    mx = 0; my = 0; exp_drop = 0;
  endtask

  task automatic model_pixel(input int l);
    if (l >= 1 && l <= NL - 1) begin
      if (m_cnt[l] == 0) begin
        m_xmin[l] = mx; m_xmax[l] = mx; m_ymin[l] = my; m_ymax[l] = my; m_cnt[l] = 1;
      end else begin
        if (mx < m_xmin[l]) m_xmin[l] = mx;
        if (mx > m_xmax[l]) m_xmax[l] = mx;
        if (my < m_ymin[l]) m_ymin[l] = my;
        if (my > m_ymax[l]) m_ymax[l] = my;
        if (m_cnt[l] < 65535) m_cnt[l]++;
      end
    end
  endtask

  task automatic model_counters(input bit e, input bit hs, input bit vs);
    if (vs) begin
      mx = 0; my = 0;
    end else if (hs) begin
      mx = 0; my = (my + 1) % 2048;
    end else if (e) begin
      mx = (mx + 1) % 2048;
    end
  endtask

  // One accumulation-phase cycle.
  task automatic drive(input bit e, input logic [7:0] l, input bit hs, input bit vs);
    en = e; label = l; hsync = hs; vsync = vs;
    if (e) model_pixel(int'(l));
    model_counters(e, hs, vs);
    @(posedge clk); #1;
    en = 0; hsync = 0; vsync = 0;
  endtask

  // mode 0: ready always; 1: random ready; 2: ready held low 5 cycles on the first entry.
  task automatic drain(input bit vs_en, input logic [7:0] vs_lbl, input int mode, input bit inject);
    int   stalls = 0;
    int   holds  = 0;
    bit   done   = 0;
    ent_t e;
    en = vs_en; label = vs_lbl; vsync = 1; hsync = 0;
    if (vs_en) model_pixel(int'(vs_lbl));
    model_counters(vs_en, 0, 1);
    exp_q.delete();
    xfer_q.delete();
    for (int l = 1; l < NL; l++) begin
      if (m_cnt[l] != 0) begin
        e.lbl = l; e.xmin = m_xmin[l]; e.xmax = m_xmax[l];
        e.ymin = m_ymin[l]; e.ymax = m_ymax[l]; e.cnt = m_cnt[l];
        exp_q.push_back(e);
        m_cnt[l] = 0;
      end
    end
    @(posedge clk); #1;
    en = 0; vsync = 0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      case (mode)
        0:       out_ready = 1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = !(out_valid && holds < 5);
          if (!out_ready) holds++;
        end
      endcase
      if (inject && cyc <= 20) begin
        en = 1'($urandom_range(0, 1)); label = 8'($urandom); vsync = (cyc == 10);
        model_counters(en, 0, vsync);
        if (en || vsync) exp_drop = 1;
      end
      @(negedge clk);
      if (frame_done) begin
        check("fd_cycle", cyc, 32 + stalls);
        check("fd_valid_low", out_valid, 0);
        check("fd_queue_empty", exp_q.size(), 0);
        done = 1;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_valid", 1, 0);
        end else begin
          check("out_label", out_label, exp_q[0].lbl);
          check("out_xmin",  out_xmin,  exp_q[0].xmin);
          check("out_xmax",  out_xmax,  exp_q[0].xmax);
          check("out_ymin",  out_ymin,  exp_q[0].ymin);
          check("out_ymax",  out_ymax,  exp_q[0].ymax);
          check("out_count", out_count, exp_q[0].cnt);
          if (out_ready) xfer_q.push_back(exp_q.pop_front());
          else stalls++;
        end
      end
      @(posedge clk); #1;
      en = 0; vsync = 0;
    end
    if (!done) check("fd_timeout", 0, 1);
    check("fd_single_pulse", frame_done, 0);
    check("dropped_flag", dropped, exp_drop);
    out_ready = 1;
    last_stalls = stalls;
  endtask

  function automatic logic [7:0] rand_label();
    int pick = $urandom_range(0, 9);
    if (pick == 0) return 8'd0;
    if (pick == 1) return 8'd255;
    if (pick == 2) return 8'($urandom);
    return 8'($urandom_range(1, NL - 1));
  endfunction

  initial begin
    int fd_seen;
    reset_n = 0; en = 0; hsync = 0; vsync = 0; label = 0; out_ready = 1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
      label = 8'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
    end
    en = 0; hsync = 0; vsync = 0; out_ready = 1;
    model_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_dropped", dropped, 0);
    reset_n = 1;
    @(posedge clk); #1;

    // Empty frame: 31 quiet cycles then frame_done
    drain(0, 8'd0, 0, 0);
    check("empty_xfers", xfer_q.size(), 0);

    // Single object at (5,0) (6,0) (5,1)
    for (int i = 0; i < 5; i++) drive(1, 8'd0, 0, 0);
    drive(1, 8'd3, 0, 0);
    drive(1, 8'd3, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 8'd0, 0, 0);
    drive(1, 8'd3, 0, 0);
    drain(0, 8'd0, 0, 0);
    check("single_xfers", xfer_q.size(), 1);
    if (xfer_q.size() == 1) begin
      check("single_label", xfer_q[0].lbl, 3);
      check("single_xmin", xfer_q[0].xmin, 5);
      check("single_xmax", xfer_q[0].xmax, 6);
      check("single_ymin", xfer_q[0].ymin, 0);
      check("single_ymax", xfer_q[0].ymax, 1);
      check("single_count", xfer_q[0].cnt, 3);
    end

    // Filtering and order
    drive(1, 8'd0, 0, 0);
    drive(1, 8'd255, 0, 0);
    drive(1, 8'd40, 0, 0);
    drive(1, 8'd7, 0, 0);
    drive(0, 8'd0, 1, 0);
    drive(1, 8'd2, 0, 0);
    drain(0, 8'd0, 0, 0);
    check("filter_xfers", xfer_q.size(), 2);
    if (xfer_q.size() == 2) begin
      check("filter_first", xfer_q[0].lbl, 2);
      check("filter_second", xfer_q[1].lbl, 7);
      check("filter_count", xfer_q[1].cnt, 1);
    end

    // Backpressure on the first of two entries; vsync cycle also carries a pixel
    drive(1, 8'd4, 0, 0);
    drive(1, 8'd9, 0, 0);
    drain(1, 8'd9, 2, 0);
    check("bp_stalls", last_stalls, 5);
    check("bp_xfers", xfer_q.size(), 2);

    // Random frames with random ready
    for (int f = 0; f < 3; f++) begin
      for (int ln = 0; ln < 4; ln++) begin
        for (int p = 0; p < 20; p++) drive(1'($urandom_range(0, 1)), rand_label(), 0, 0);
        drive(0, 8'd0, 1, 0);
      end
      drain(0, 8'd0, 1, 0);
    end

    // Drop during drain, then a clean frame
    drive(1, 8'd5, 0, 0);
    drive(1, 8'd6, 1, 0);
    drain(0, 8'd0, 0, 1);
    check("drop_set", dropped, 1);
    for (int p = 0; p < 10; p++) drive(1, rand_label(), 0, 0);
    drain(0, 8'd0, 1, 0);
    check("drop_sticky", dropped, 1);

    // Saturation
    for (int i = 0; i < 65539; i++) drive(1, 8'd1, 0, 0);
    drain(0, 8'd0, 0, 0);
    check("sat_xfers", xfer_q.size(), 1);
    if (xfer_q.size() == 1) check("sat_count", xfer_q[0].cnt, 65535);

    // Reset mid-drain
    drive(1, 8'd1, 0, 0);
    drive(1, 8'd20, 0, 0);
    out_ready = 0;
    vsync = 1;
    @(posedge clk); #1;
    vsync = 0;
    @(posedge clk); #1;
    check("mid_valid_before_rst", out_valid, 1);
    reset_n = 0;
    @(posedge clk); #1;
    check("mid_valid_after_rst", out_valid, 0);
    check("mid_fd_after_rst", frame_done, 0);
    reset_n = 1; out_ready = 1;
    model_reset();
    fd_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done || out_valid) fd_seen++;
      @(posedge clk); #1;
    end
    check("mid_no_output", fd_seen, 0);
    drain(0, 8'd0, 0, 0);
    check("mid_table_empty", xfer_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/label_bbox_accumulator.md
# label_bbox_accumulator

Downstream consumer of the connected-components label stream. It accumulates a bounding box and a pixel count for each component label over one frame. On end-of-frame it drains every non-empty entry through a valid/ready output port, then clears the table for the next frame. It sits directly after `connected_components_labeling`, on its 8-bit `q` stream, and feeds object reporting.

## Interface
- `WORD_SIZE`, 8: label width; must match the global word size.
- `NUM_LABELS`, 32: table depth. Labels 1..NUM_LABELS-1 are tracked.
- `COORD_WIDTH`, 11: width of the x/y coordinate counters and of the box fields.
- `COUNT_WIDTH`, 16: width of the pixel-count field; the count saturates.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `en`  in  1: a pixel is present on `label` this cycle.
- `hsync`  in  1: one-cycle end-of-line pulse.
- `vsync`  in  1: one-cycle end-of-frame pulse.
- `label`  in  WORD_SIZE: component label of the current pixel.
- `out_valid`  out  1: a table entry is presented.
- `out_ready`  in  1: the consumer accepts the entry.
- `out_label`  out  WORD_SIZE: label index of the presented entry.
- `out_xmin`, `out_xmax`, `out_ymin`, `out_ymax`  out  COORD_WIDTH each: bounding box of the entry.
- `out_count`  out  COUNT_WIDTH: pixel count of the entry.
- `frame_done`  out  1: one-cycle pulse when the drain completes.
- `dropped`  out  1: sticky flag; a pixel or `vsync` was discarded during the drain.

## Operation
- **Coordinates**
  - `x` increments on every cycle with `en`=1 and wraps modulo 2^COORD_WIDTH.
  - `hsync`=1 sets `x`<=0 and `y`<=`y`+1 (wraps).
  - `vsync`=1 sets `x`<=0 and `y`<=0.
  - Counters advance in both states.
- **Table entry** per label L: `count`, `xmin`, `xmax`, `ymin`, `ymax`, all registers.
- **State ACCUM** (reset state)
  - A pixel is accumulated when `en`=1 and 1 <= `label` <= NUM_LABELS-1.
  - Label 0 (background), label 255 (conflict) and out-of-range labels are ignored.
  - If `count`[L]==0: `xmin`=`xmax`=`x`, `ymin`=`ymax`=`y`, `count`=1.
  - Otherwise: min/max update against the current `x`,`y`; `count`+1, saturating at 2^COUNT_WIDTH-1.
  - `vsync`=1 moves to DUMP with `idx`<=1.
- **State DUMP**
  - If `count`[`idx`]==0: `idx`+1 next cycle, no output.
  - Otherwise: `out_valid`=1 and the `out_*` fields show entry `idx`; `out_label`=`idx`.
  - On transfer (`out_valid`&&`out_ready`): the entry's `count` clears to 0, and `idx`+1.
  - When `idx`==NUM_LABELS-1 and that entry completes (skipped or transferred): go to ACCUM and pulse `frame_done`.
- **Inputs during DUMP**
  - `en`=1 with any label: the pixel is discarded and `dropped`<=1.
  - `vsync`=1: ignored for state purposes, `dropped`<=1. Counters still reset.
- **Reset**
  - All `count`=0, `x`=`y`=0, state ACCUM, `idx`=1, `out_valid`=0, `frame_done`=0, `dropped`=0.
  - A reset mid-DUMP abandons the drain immediately; no further `out_valid`.
- **Output fields**
  - `out_*` fields are don't-care while `out_valid`=0.
  - While `out_valid`=1 they are stable until transfer.

## Timing
- A pixel at cycle t is visible in the table at t+1.
- Same-cycle `en` and `hsync`, or `en` and `vsync`: the pixel uses the pre-update `x`,`y` and is accumulated; the counter update follows.
- `vsync` at cycle t gives state DUMP at t+1. `out_valid` rises at t+1 if entry 1 is non-empty.
- Each empty entry costs 1 cycle. Each non-empty entry costs at least 1 cycle, plus the cycles `out_ready` is held low.
- Drain length with all `out_ready`=1 is NUM_LABELS-1 cycles. `frame_done` is high in the cycle after the final entry completes, coinciding with the first ACCUM cycle.
- `out_valid` must not deassert without a transfer. `out_ready` may toggle freely.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with random inputs -> `out_valid`=0, `frame_done`=0, `dropped`=0. A `vsync` right after reset with no pixels -> 31 cycles of no `out_valid`, then `frame_done` pulses once.
- **Single object:** label 3 at (x,y) = (5,0), (6,0), (5,1) via `en`/`hsync`, then `vsync` with `out_ready`=1 -> exactly one transfer: `out_label`=3, xmin=5, xmax=6, ymin=0, ymax=1, count=3.
- **Filtering and order:** labels 0, 255, 40 and 7 on one line, then label 2 on the next line -> transfers for label 2 then label 7 only, in index order, each count=1.
- **Backpressure:** two non-empty entries, `out_ready` low for 5 cycles on the first -> fields stable throughout, with no skip or duplicate. The second entry follows after `out_ready` rises.
- **Drop and restart:** pixels and a `vsync` injected during DUMP -> `dropped`=1 and stays 1. Those pixels are absent from the next frame's output, and the next frame's table starts empty.
- **Saturation and reset mid-drain:** 2^16+3 pixels of label 1 -> count=65535. A second run asserts `reset_n`=0 during DUMP -> `out_valid`=0 the next cycle, no `frame_done`, and the table is empty on the next frame.
